// File: rtl/sp_ram_arbiter.sv
// Two-client arbiter in front of a single-port synchronous-read block RAM.
// Optional macro SP_ARB_RR_EN swaps the fixed-priority/starvation guard for round robin.
module sp_ram_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              gnt_a,
  output logic              rvalid_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_b,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_wre,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_reset,
  input  logic [DATA_W-1:0] ram_dout
);

  logic contested;
  logic win_b;
  logic tag1_valid, tag1_id;
  logic tag2_valid, tag2_id;

  assign contested = req_a & req_b;

`ifdef SP_ARB_RR_EN
  // Remembers who took the most recent contested cycle; the other side gets the next one.
  logic last_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      last_b <= 1'b0;
    else if (contested)
      last_b <= win_b;
  end

  always_comb begin
    win_b = 1'b0;
    if (req_b && !req_a)
      win_b = 1'b1;
    else if (contested)
      win_b = ~last_b;
  end
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      starve_cnt <= '0;
    else if (!req_b || gnt_b)
      starve_cnt <= '0;
    else if (starve_cnt != LIMIT)
      starve_cnt <= starve_cnt + 4'd1;
  end

  always_comb begin
    win_b = 1'b0;
    if (req_b && !req_a)
      win_b = 1'b1;
    else if (contested)
      win_b = (starve_cnt == LIMIT);
  end
`endif

  // Grants are forced low while reset is held so no request leaks through.
  assign gnt_a = reset_n & req_a & ~win_b;
  assign gnt_b = reset_n & req_b & win_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_ce  <= 1'b0;
      ram_wre <= 1'b0;
      ram_ad  <= '0;
      ram_din <= '0;
    end else begin
      ram_ce  <= gnt_a | gnt_b;
      ram_wre <= (gnt_a & we_a) | (gnt_b & we_b);
      if (gnt_a) begin
        ram_ad  <= addr_a;
        ram_din <= wdata_a;
      end else if (gnt_b) begin
        ram_ad  <= addr_b;
        ram_din <= wdata_b;
      end
    end
  end

  // Two-stage tag shift lines up with command register plus RAM read register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag1_valid <= 1'b0;
      tag1_id    <= 1'b0;
      tag2_valid <= 1'b0;
      tag2_id    <= 1'b0;
    end else begin
      tag1_valid <= (gnt_a & ~we_a) | (gnt_b & ~we_b);
      tag1_id    <= gnt_b;
      tag2_valid <= tag1_valid;
      tag2_id    <= tag1_id;
    end
  end

  assign rvalid_a  = tag2_valid & ~tag2_id;
  assign rvalid_b  = tag2_valid & tag2_id;
  assign rdata     = tag2_valid ? ram_dout : '0;
  assign ram_oce   = 1'b1;
  assign ram_reset = ~reset_n;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed self-checking bench for sp_ram_arbiter with a behavioural RAM and read scoreboard.
// Contention expectations follow SP_ARB_RR_EN when that macro is defined.
module tb_sp_ram_arbiter;

   localparam int ADDR_W = 13;
   localparam int DATA_W = 8;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
   logic [ADDR_W-1:0] addr_a = '0, addr_b = '0;
   logic [DATA_W-1:0] wdata_a = '0, wdata_b = '0;
   logic              gnt_a, gnt_b, rvalid_a, rvalid_b;
   logic [DATA_W-1:0] rdata, ram_din, ram_dout;
   logic              ram_ce, ram_oce, ram_wre, ram_reset;
   logic [ADDR_W-1:0] ram_ad;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   typedef struct packed {
      logic        id;
      logic [7:0]  data;
      logic [31:0] cyc;
   } exp_t;

   exp_t sb[$];
   exp_t monE;
   logic [7:0] shadow [8192];
   logic [7:0] mem [8192];
   logic [7:0] doutQ;

   logic              prevCe = 1'b0, prevWe = 1'b0;
   logic [ADDR_W-1:0] prevAd = '0;
   logic [DATA_W-1:0] prevDin = '0;

   sp_ram_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a), .gnt_a(gnt_a), .rvalid_a(rvalid_a),
      .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b), .gnt_b(gnt_b), .rvalid_b(rvalid_b),
      .rdata(rdata), .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre), .ram_ad(ram_ad),
      .ram_din(ram_din), .ram_reset(ram_reset), .ram_dout(ram_dout)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Cycle counter used for read-return timing.
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural single-port RAM write port.
   always @(posedge clk) begin
      if (ram_ce && ram_wre) mem[ram_ad] <= ram_din;
   end

   // Behavioural RAM one-cycle synchronous read with async output reset.
   always @(posedge clk or posedge ram_reset) begin
      if (ram_reset) doutQ <= '0;
      else if (ram_ce && !ram_wre) doutQ <= mem[ram_ad];
   end

   assign ram_dout = doutQ;

   // Read-return monitor: pops the scoreboard whenever a read comes back.
   always @(negedge clk) begin
      if (!reset_n) begin
         total++;
         if (rvalid_a !== 1'b0) begin bad++; $error("[TB] FAIL rst_rvalid_a observed=%0h expected=0", rvalid_a); end
         total++;
         if (rvalid_b !== 1'b0) begin bad++; $error("[TB] FAIL rst_rvalid_b observed=%0h expected=0", rvalid_b); end
         total++;
         if (rdata !== 8'h00) begin bad++; $error("[TB] FAIL rst_rdata observed=%0h expected=0", rdata); end
      end else begin
         if (sb.size() > 0 && sb[0].cyc < 32'(cyc)) begin
            total++;
            if (32'(cyc) !== sb[0].cyc) begin bad++; $error("[TB] FAIL missing_rvalid_cycle observed=%0h expected=%0h", cyc, sb[0].cyc); end
            void'(sb.pop_front());
         end
         if (rvalid_a || rvalid_b) begin
            if (sb.size() == 0) begin
               total++;
               if ({rvalid_a, rvalid_b} !== 2'b00) begin bad++; $error("[TB] FAIL spurious_rvalid observed=%0h expected=0", {rvalid_a, rvalid_b}); end
            end else begin
               monE = sb.pop_front();
               total++;
               if (rvalid_a !== ~monE.id) begin bad++; $error("[TB] FAIL rvalid_a observed=%0h expected=%0h", rvalid_a, ~monE.id); end
               total++;
               if (rvalid_b !== monE.id) begin bad++; $error("[TB] FAIL rvalid_b observed=%0h expected=%0h", rvalid_b, monE.id); end
               total++;
               if (rdata !== monE.data) begin bad++; $error("[TB] FAIL rdata observed=%0h expected=%0h", rdata, monE.data); end
               total++;
               if (32'(cyc) !== monE.cyc) begin bad++; $error("[TB] FAIL rvalid_cycle observed=%0h expected=%0h", cyc, monE.cyc); end
            end
         end else begin
            total++;
            if (rdata !== 8'h00) begin bad++; $error("[TB] FAIL idle_rdata observed=%0h expected=0", rdata); end
         end
      end
   end

   // Drives both client request buses.
   task automatic applyStimulus(input logic ra, input logic wa, input logic [12:0] aa, input logic [7:0] da,
                                input logic rb, input logic wb, input logic [12:0] ab, input logic [7:0] db);
      req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
      req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
   endtask

   // Checks grants for this cycle and the command registered from the previous one.
   task automatic checkOutput(input logic ea, input logic eb);
      @(negedge clk);
      total++;
      if (gnt_a !== ea) begin bad++; $error("[TB] FAIL gnt_a observed=%0h expected=%0h", gnt_a, ea); end
      total++;
      if (gnt_b !== eb) begin bad++; $error("[TB] FAIL gnt_b observed=%0h expected=%0h", gnt_b, eb); end
      total++;
      if (ram_ce !== prevCe) begin bad++; $error("[TB] FAIL ram_ce observed=%0h expected=%0h", ram_ce, prevCe); end
      if (prevCe) begin
         total++;
         if (ram_wre !== prevWe) begin bad++; $error("[TB] FAIL ram_wre observed=%0h expected=%0h", ram_wre, prevWe); end
         total++;
         if (ram_ad !== prevAd) begin bad++; $error("[TB] FAIL ram_ad observed=%0h expected=%0h", ram_ad, prevAd); end
         if (prevWe) begin
            total++;
            if (ram_din !== prevDin) begin bad++; $error("[TB] FAIL ram_din observed=%0h expected=%0h", ram_din, prevDin); end
         end
      end else begin
         total++;
         if (ram_wre !== 1'b0) begin bad++; $error("[TB] FAIL ram_wre_idle observed=%0h expected=0", ram_wre); end
      end
      prevCe = ea | eb;
      if (ea) begin
         prevWe = we_a; prevAd = addr_a; prevDin = wdata_a;
         if (we_a) shadow[addr_a] = wdata_a;
         else sb.push_back('{id: 1'b0, data: shadow[addr_a], cyc: 32'(cyc + 2)});
      end else if (eb) begin
         prevWe = we_b; prevAd = addr_b; prevDin = wdata_b;
         if (we_b) shadow[addr_b] = wdata_b;
         else sb.push_back('{id: 1'b1, data: shadow[addr_b], cyc: 32'(cyc + 2)});
      end
   endtask

   // One full bench cycle: drive after the edge, check before the next.
   task automatic step(input logic ra, input logic wa, input logic [12:0] aa, input logic [7:0] da,
                       input logic rb, input logic wb, input logic [12:0] ab, input logic [7:0] db,
                       input logic ea, input logic eb);
      @(posedge clk); #1;
      applyStimulus(ra, wa, aa, da, rb, wb, ab, db);
      checkOutput(ea, eb);
   endtask

   // Idle cycles with no requests.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 13'h0, 8'h0, 0, 0, 13'h0, 8'h0, 0, 0);
   endtask

   // Watchdog against hangs.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   // Main directed sequence.
   initial begin
      applyStimulus(1, 0, 13'h0100, 8'h00, 1, 0, 13'h0200, 8'h00);
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if (gnt_a !== 1'b0) begin bad++; $error("[TB] FAIL reset_gnt_a observed=%0h expected=0", gnt_a); end
      total++;
      if (gnt_b !== 1'b0) begin bad++; $error("[TB] FAIL reset_gnt_b observed=%0h expected=0", gnt_b); end
      total++;
      if (ram_ce !== 1'b0) begin bad++; $error("[TB] FAIL reset_ram_ce observed=%0h expected=0", ram_ce); end
      total++;
      if (ram_wre !== 1'b0) begin bad++; $error("[TB] FAIL reset_ram_wre observed=%0h expected=0", ram_wre); end
      total++;
      if (ram_ad !== 13'h0) begin bad++; $error("[TB] FAIL reset_ram_ad observed=%0h expected=0", ram_ad); end
      total++;
      if (ram_din !== 8'h00) begin bad++; $error("[TB] FAIL reset_ram_din observed=%0h expected=0", ram_din); end
      total++;
      if (ram_oce !== 1'b1) begin bad++; $error("[TB] FAIL ram_oce observed=%0h expected=1", ram_oce); end
      total++;
      if (ram_reset !== 1'b1) begin bad++; $error("[TB] FAIL ram_reset_on observed=%0h expected=1", ram_reset); end
      @(posedge clk); #1;
      applyStimulus(0, 0, 13'h0, 8'h0, 0, 0, 13'h0, 8'h0);
      reset_n = 1'b1;
      #1;
      total++;
      if (ram_reset !== 1'b0) begin bad++; $error("[TB] FAIL ram_reset_off observed=%0h expected=0", ram_reset); end

      step(1, 1, 13'h1234, 8'h5A, 0, 0, 13'h0, 8'h0, 1, 0);
      idle(1);
      step(1, 0, 13'h1234, 8'h00, 0, 0, 13'h0, 8'h0, 1, 0);
      idle(3);

      step(1, 1, 13'h1FFF, 8'hC3, 0, 0, 13'h0, 8'h0, 1, 0);
      step(1, 0, 13'h1FFF, 8'h00, 0, 0, 13'h0, 8'h0, 1, 0);
      idle(3);

      for (int i = 0; i < 4; i++) step(0, 0, 13'h0, 8'h0, 1, 1, 13'(i), 8'(8'h10 + i), 0, 1);
      for (int i = 0; i < 4; i++) step(0, 0, 13'h0, 8'h0, 1, 0, 13'(i), 8'h00, 0, 1);
      idle(3);

      for (int i = 0; i < 12; i++) begin
`ifdef SP_ARB_RR_EN
         step(1, 0, 13'h1FFF, 8'h00, 1, 0, 13'h0003, 8'h00, (i % 2) != 0, (i % 2) == 0);
`else
         step(1, 0, 13'h1FFF, 8'h00, 1, 0, 13'h0003, 8'h00, (i % 5) != 4, (i % 5) == 4);
`endif
      end
      idle(3);

      step(1, 0, 13'h1234, 8'h00, 0, 0, 13'h0, 8'h0, 1, 0);
      @(posedge clk); #1;
      reset_n = 1'b0;
      sb.delete();
      prevCe = 1'b0;
      applyStimulus(1, 0, 13'h1234, 8'h00, 0, 0, 13'h0, 8'h0);
      checkOutput(0, 0);
      total++;
      if (rdata !== 8'h00) begin bad++; $error("[TB] FAIL midreset_rdata observed=%0h expected=0", rdata); end
      @(posedge clk); #1;
      reset_n = 1'b1;
      applyStimulus(1, 0, 13'h1FFF, 8'h00, 0, 0, 13'h0, 8'h0);
      checkOutput(1, 0);
      idle(4);
      total++;
      if (sb.size() !== 0) begin bad++; $error("[TB] FAIL scoreboard_empty observed=%0d expected=0", sb.size()); end

      $display("[TB] test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
